// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory responder: RV32I load/store funct3
// codes, the responder FSM state type, and the access-legality helper.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Returns 1 when the request is NOT legal: unknown size code for the
  // direction, or a halfword/word address that is not naturally aligned.
  // The depth-dependent range check lives in the responder itself, since
  // it depends on the array size.
  function automatic logic legal_access(input logic [2:0]  funct3,
                                        input logic        we,
                                        input logic [31:0] addr);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_B:  bad = 1'b0;
      F3_BU: bad = we;
      F3_H:  bad = addr[0];
      F3_HU: bad = we | addr[0];
      F3_W:  bad = addr[1] | addr[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a 32-bit memory word and an RV32I access.
// Ports:
//   addr_lo  byte offset within the word (addr[1:0])
//   funct3   RV32I size/sign code
//   wdata    right-justified store data
//   rword    raw word read from the array
//   be       per-byte write enable for a store (0 for unknown codes)
//   wword    store data replicated onto every lane it may land on
//   rext     load value, sign- or zero-extended to 32 bits
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Store side: replicate the data so be alone selects the target lanes.
  always_comb begin
    be    = 4'b0000;
    wword = wdata;
    case (funct3)
      F3_B: begin
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
      end
      F3_H: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
      end
      F3_W: begin
        be    = 4'b1111;
        wword = wdata;
      end
      default: begin
        be    = 4'b0000;
        wword = wdata;
      end
    endcase
  end

  // Load side: little-endian lane pick, then extend.
  always_comb begin
    rbyte = 8'h00;
    rhalf = 16'h0000;
    rext  = 32'h0;
    case (addr_lo)
      2'd0: rbyte = rword[7:0];
      2'd1: rbyte = rword[15:8];
      2'd2: rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (funct3)
      F3_B:  rext = {{24{rbyte[7]}}, rbyte};
      F3_BU: rext = {24'h0, rbyte};
      F3_H:  rext = {{16{rhalf[15]}}, rhalf};
      F3_HU: rext = {16'h0, rhalf};
      F3_W:  rext = rword;
      default: rext = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multi-cycle RISC-V core. Accepts one
// load/store at a time into a unified word array, waits LATENCY cycles
// from acceptance, then returns a single-cycle response.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake: a request is taken on a rising
//                       edge where both are high; req_ready is high only
//                       in IDLE, and the requester must hold its fields
//                       stable while req_valid is high and not yet taken
//   req_we, req_addr, req_wdata, req_funct3  request fields
//   resp_valid          one-cycle pulse, no back-pressure
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_err            misaligned, out of range, or illegal funct3
module mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,  // power of two, at least 2
  parameter int    LATENCY     = 2,     // at least 1
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  logic [31:0] mem [DEPTH_WORDS];

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          accept, access;

  logic        r_we;
  logic [31:0] r_addr, r_wdata;
  logic [2:0]  r_funct3;

  // With LATENCY==1 the access happens on the accept edge itself, before
  // the request registers hold anything, so the live request is used then.
  logic        a_we;
  logic [31:0] a_addr, a_wdata;
  logic [2:0]  a_funct3;

  logic [AW-1:0] idx;
  logic [31:0]   rword, wword, rext;
  logic [3:0]    be;
  logic          range_err, err;

  // Next state; access marks the edge that enters RESP.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    access  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_n = RESP;
            access  = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n = RESP;
          access  = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (access) begin
        resp_err   <= err;
        resp_rdata <= (err || a_we) ? 32'h0 : rext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      r_we     <= req_we;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_funct3 <= req_funct3;
    end
  end

  always_comb begin
    a_we     = r_we;
    a_addr   = r_addr;
    a_wdata  = r_wdata;
    a_funct3 = r_funct3;
    if (state == IDLE) begin
      a_we     = req_we;
      a_addr   = req_addr;
      a_wdata  = req_wdata;
      a_funct3 = req_funct3;
    end
  end

  assign idx       = a_addr[AW+1:2];
  assign rword     = mem[idx];
  assign range_err = ({2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign err       = legal_access(a_funct3, a_we, a_addr) | range_err;

  mem_lane_align u_align (
    .addr_lo (a_addr[1:0]),
    .funct3  (a_funct3),
    .wdata   (a_wdata),
    .rword   (rword),
    .be      (be),
    .wword   (wword),
    .rext    (rext)
  );

  // Array is never cleared by reset; a reset on the RESP-entry edge
  // suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && access && a_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  import riscv_mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // LATENCY=2 instance
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  // LATENCY=1 instance
  logic        l1_valid, l1_ready, l1_we;
  logic [31:0] l1_addr, l1_wdata;
  logic [2:0]  l1_funct3;
  logic        l1_resp_valid, l1_resp_err;
  logic [31:0] l1_resp_rdata;

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (l1_valid),
    .req_ready  (l1_ready),
    .req_we     (l1_we),
    .req_addr   (l1_addr),
    .req_wdata  (l1_wdata),
    .req_funct3 (l1_funct3),
    .resp_valid (l1_resp_valid),
    .resp_rdata (l1_resp_rdata),
    .resp_err   (l1_resp_err)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Entered and left at a negedge with the LATENCY=2 responder idle.
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    exp_q.push_back(exp_rdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    check({tag, "_ready_idle"}, req_ready, 1'b1);
    @(posedge clk);            // accept edge
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 16) begin
      check({tag, "_ready_busy"}, req_ready, 1'b0);
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 2);
    check({tag, "_resp_valid"}, resp_valid, 1'b1);
    check({tag, "_ready_resp"}, req_ready, 1'b0);
    check({tag, "_rdata"}, resp_rdata, exp_q.pop_front());
    check({tag, "_err"}, resp_err, exp_err);
    @(negedge clk);
    check({tag, "_pulse_end"}, resp_valid, 1'b0);
    check({tag, "_ready_back"}, req_ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = F3_W;
    l1_valid = 1'b0; l1_we = 1'b0; l1_addr = '0; l1_wdata = '0; l1_funct3 = F3_W;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready",  req_ready, 1'b1);
    check("rst_valid",  resp_valid, 1'b0);
    check("rst_rdata",  resp_rdata, 32'h0);
    check("rst_err",    resp_err, 1'b0);
    check("rst_state",  32'(dut.state), 32'(IDLE));
    check("rst_l1_rdy", l1_ready, 1'b1);

    do_req("sw10",   1'b1, 32'h10, 32'hDEADBEEF, F3_W,  32'h0,        1'b0);
    do_req("lw10",   1'b0, 32'h10, 32'h0,        F3_W,  32'hDEADBEEF, 1'b0);
    do_req("lb13",   1'b0, 32'h13, 32'h0,        F3_B,  32'hFFFFFFDE, 1'b0);
    do_req("lbu13",  1'b0, 32'h13, 32'h0,        F3_BU, 32'h000000DE, 1'b0);
    do_req("lh12",   1'b0, 32'h12, 32'h0,        F3_H,  32'hFFFFDEAD, 1'b0);
    do_req("lhu10",  1'b0, 32'h10, 32'h0,        F3_HU, 32'h0000BEEF, 1'b0);
    do_req("sb11",   1'b1, 32'h11, 32'h12345677, F3_B,  32'h0,        1'b0);
    do_req("lw10b",  1'b0, 32'h10, 32'h0,        F3_W,  32'hDEAD77EF, 1'b0);
    do_req("sh12",   1'b1, 32'h12, 32'hAAAA5555, F3_H,  32'h0,        1'b0);
    do_req("lw10c",  1'b0, 32'h10, 32'h0,        F3_W,  32'h555577EF, 1'b0);
    do_req("lh12b",  1'b0, 32'h12, 32'h0,        F3_H,  32'h00005555, 1'b0);
    do_req("lb11",   1'b0, 32'h11, 32'h0,        F3_B,  32'h00000077, 1'b0);
    do_req("lw02",   1'b0, 32'h02, 32'h0,        F3_W,  32'h0,        1'b1);
    do_req("sw04",   1'b1, 32'h04, 32'hCAFEF00D, F3_W,  32'h0,        1'b0);
    do_req("sh05",   1'b1, 32'h05, 32'h0000FFFF, F3_H,  32'h0,        1'b1);
    do_req("lw04",   1'b0, 32'h04, 32'h0,        F3_W,  32'hCAFEF00D, 1'b0);
    do_req("lw_oor", 1'b0, 32'h1000, 32'h0,      F3_W,  32'h0,        1'b1);
    do_req("f3_011", 1'b0, 32'h10, 32'h0,        3'b011, 32'h0,       1'b1);
    do_req("sw20",   1'b1, 32'h20, 32'h5A5AA5A5, F3_W,  32'h0,        1'b0);

    // Reset during WAIT drops the store.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
    req_wdata = 32'h11111111; req_funct3 = F3_W;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rstw_in_wait", 32'(dut.state), 32'(WAIT));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_valid", resp_valid, 1'b0);
    check("rstw_ready", req_ready, 1'b1);
    check("rstw_state", 32'(dut.state), 32'(IDLE));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstw_no_resp", resp_valid, 1'b0);
    end
    do_req("lw20", 1'b0, 32'h20, 32'h0, F3_W, 32'h5A5AA5A5, 1'b0);

    // LATENCY=1: req_valid held high, every other cycle accepted.
    l1_valid = 1'b1; l1_we = 1'b1; l1_addr = 32'h40; l1_funct3 = F3_W; l1_wdata = 32'h100;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("l1_resp",  l1_resp_valid, 32'(i % 2 == 1));
      check("l1_ready", l1_ready,      32'(i % 2 == 0));
      l1_wdata = 32'h100 + 32'(i);
    end
    // Last accepted store carried 0x106; 0x107 arrived during RESP.
    l1_we = 1'b0;
    @(negedge clk);
    l1_valid = 1'b0;
    check("l1_lw_valid", l1_resp_valid, 1'b1);
    check("l1_lw_rdata", l1_resp_rdata, 32'h106);
    check("l1_lw_err",   l1_resp_err, 1'b0);
    @(negedge clk);
    check("l1_lw_end",   l1_resp_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
